// File: rtl/sram_req_arbiter_pkg.sv
// rtl/sram_req_arbiter_pkg.sv - owner encodings, grant-state encodings and depth limit for the SRAM arbiter
package sram_req_arbiter_pkg;

    localparam int OUTSTANDING_MAX = 4;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_I = 2'd1,
        ST_LOCK_D = 2'd2
    } state_e;

endpackage

// File: rtl/arb_owner_fifo.sv
// rtl/arb_owner_fifo.sv - owner-bit FIFO recording which master each accepted request belongs to
module arb_owner_fifo #(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          din,
    output logic          dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    // A pop in the same cycle frees the slot a push into a full FIFO needs
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - two-master SRAM-like request arbiter with in-order response routing
// Optional round-robin conflict policy: define SRAM_ARB_ROUND_ROBIN_EN (default is fixed data priority).
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        sram_req,
    output logic        sram_wr,
    output logic [1:0]  sram_size,
    output logic [3:0]  sram_wstrb,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok,
    input  logic [31:0] sram_rdata,

    output logic        arb_err
);

    localparam int DEPTH = (OUTSTANDING > OUTSTANDING_MAX) ? OUTSTANDING_MAX :
                           (OUTSTANDING < 1) ? 1 : OUTSTANDING;
    localparam int CW    = $clog2(DEPTH + 1);

    state_e        r_state;
    state_e        w_next_state;
    owner_e        w_grant;
    logic          w_master_req;
    logic          w_sram_req;
    logic          w_handshake;
    logic          w_pop;
    logic          w_can_issue;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_fifo_dout;
    logic [CW-1:0] w_fifo_count;
    logic          r_arb_err;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    owner_e        r_last_owner;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_owner <= OWNER_INST;
        end else if (w_handshake) begin
            r_last_owner <= w_grant;
        end
    end
`endif

    assign w_pop       = sram_data_ok & (w_fifo_count != '0);
    assign w_can_issue = ~w_fifo_full | w_pop;
    assign w_handshake = w_sram_req & sram_addr_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant      = OWNER_DATA;
        case (r_state)
            ST_LOCK_I: w_grant = OWNER_INST;
            ST_LOCK_D: w_grant = OWNER_DATA;
            default: begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                if (inst_sram_req & data_sram_req) begin
                    w_grant = (r_last_owner == OWNER_DATA) ? OWNER_INST : OWNER_DATA;
                end else begin
                    w_grant = data_sram_req ? OWNER_DATA : OWNER_INST;
                end
`else
                w_grant = data_sram_req ? OWNER_DATA : OWNER_INST;
`endif
            end
        endcase
        w_master_req = (w_grant == OWNER_DATA) ? data_sram_req : inst_sram_req;
        w_sram_req   = w_master_req & w_can_issue;
        if (w_sram_req & sram_addr_ok) begin
            w_next_state = ST_IDLE;
        end else if (w_sram_req) begin
            w_next_state = (w_grant == OWNER_DATA) ? ST_LOCK_D : ST_LOCK_I;
        end
    end

    assign sram_req   = w_sram_req;
    assign sram_wr    = (w_grant == OWNER_DATA) ? data_sram_wr    : inst_sram_wr;
    assign sram_size  = (w_grant == OWNER_DATA) ? data_sram_size  : inst_sram_size;
    assign sram_wstrb = (w_grant == OWNER_DATA) ? data_sram_wstrb : inst_sram_wstrb;
    assign sram_addr  = (w_grant == OWNER_DATA) ? data_sram_addr  : inst_sram_addr;
    assign sram_wdata = (w_grant == OWNER_DATA) ? data_sram_wdata : inst_sram_wdata;

    assign inst_sram_addr_ok = w_handshake & (w_grant == OWNER_INST);
    assign data_sram_addr_ok = w_handshake & (w_grant == OWNER_DATA);

    assign inst_sram_data_ok = w_pop & (w_fifo_dout == OWNER_INST);
    assign data_sram_data_ok = w_pop & (w_fifo_dout == OWNER_DATA);
    assign inst_sram_rdata   = sram_rdata;
    assign data_sram_rdata   = sram_rdata;

    arb_owner_fifo #(
        .DEPTH (DEPTH)
    ) u_owner_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_handshake),
        .pop   (w_pop),
        .din   (w_grant),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // A response with nothing outstanding is a slave protocol violation; latch it until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_arb_err <= 1'b0;
        end else if (sram_data_ok & w_fifo_empty) begin
            r_arb_err <= 1'b1;
        end
    end

    assign arb_err = r_arb_err;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - directed self-checking bench for sram_req_arbiter
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        sram_req, sram_wr;
    logic [1:0]  sram_size;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_addr, sram_wdata;
    logic        sram_addr_ok, sram_data_ok;
    logic [31:0] sram_rdata;
    logic        arb_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_req_arbiter #(.OUTSTANDING(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .sram_req          (sram_req),
        .sram_wr           (sram_wr),
        .sram_size         (sram_size),
        .sram_wstrb        (sram_wstrb),
        .sram_addr         (sram_addr),
        .sram_wdata        (sram_wdata),
        .sram_addr_ok      (sram_addr_ok),
        .sram_data_ok      (sram_data_ok),
        .sram_rdata        (sram_rdata),
        .arb_err           (arb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 4'h0;
        inst_sram_addr = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 4'h0;
        data_sram_addr = 0; data_sram_wdata = 0;
        sram_addr_ok = 0; sram_data_ok = 0; sram_rdata = 0;
        do_reset();

        settle();
        chk("rst_arb_err", arb_err, 0);
        chk("rst_sram_req", sram_req, 0);
        chk("rst_inst_addr_ok", inst_sram_addr_ok, 0);
        chk("rst_data_addr_ok", data_sram_addr_ok, 0);

        // Instruction fetch, same-cycle accept, response two cycles later
        inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000; sram_addr_ok = 1;
        settle();
        chk("i_only_sram_req", sram_req, 1);
        chk("i_only_sram_addr", sram_addr, 32'h1C00_0000);
        chk("i_only_inst_addr_ok", inst_sram_addr_ok, 1);
        chk("i_only_data_addr_ok", data_sram_addr_ok, 0);
        tick();
        inst_sram_req = 0; sram_addr_ok = 0;
        tick();
        sram_data_ok = 1; sram_rdata = 32'h0280_0C0C;
        settle();
        chk("i_only_inst_data_ok", inst_sram_data_ok, 1);
        chk("i_only_inst_rdata", inst_sram_rdata, 32'h0280_0C0C);
        chk("i_only_data_data_ok", data_sram_data_ok, 0);
        tick();
        sram_data_ok = 0;

        // Simultaneous requests: data wins, inst next, responses in order
        inst_sram_req = 1; inst_sram_addr = 32'h1C00_0004;
        data_sram_req = 1; data_sram_addr = 32'h0000_1000; data_sram_wr = 1;
        data_sram_wstrb = 4'hF; data_sram_wdata = 32'hDEAD_BEEF; sram_addr_ok = 1;
        settle();
        chk("both_sram_addr", sram_addr, 32'h0000_1000);
        chk("both_sram_wr", sram_wr, 1);
        chk("both_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
        chk("both_data_addr_ok", data_sram_addr_ok, 1);
        chk("both_inst_addr_ok", inst_sram_addr_ok, 0);
        tick();
        data_sram_req = 0; data_sram_wr = 0;
        settle();
        chk("both2_sram_addr", sram_addr, 32'h1C00_0004);
        chk("both2_sram_wr", sram_wr, 0);
        chk("both2_inst_addr_ok", inst_sram_addr_ok, 1);
        tick();
        inst_sram_req = 0; sram_addr_ok = 0;
        sram_data_ok = 1; sram_rdata = 32'h0000_AAAA;
        settle();
        chk("both_rsp1_data_ok", data_sram_data_ok, 1);
        chk("both_rsp1_inst_ok", inst_sram_data_ok, 0);
        tick();
        sram_rdata = 32'h1111_2222;
        settle();
        chk("both_rsp2_inst_ok", inst_sram_data_ok, 1);
        chk("both_rsp2_data_ok", data_sram_data_ok, 0);
        chk("both_rsp2_data_rdata", data_sram_rdata, 32'h1111_2222);
        tick();
        sram_data_ok = 0;

        // Data request stalled by the slave keeps the grant while inst waits
        data_sram_req = 1; data_sram_addr = 32'h0000_2000;
        settle();
        chk("lock_c0_sram_addr", sram_addr, 32'h0000_2000);
        chk("lock_c0_data_addr_ok", data_sram_addr_ok, 0);
        tick();
        inst_sram_req = 1; inst_sram_addr = 32'h1C00_0008;
        settle();
        chk("lock_c1_sram_addr", sram_addr, 32'h0000_2000);
        chk("lock_c1_inst_addr_ok", inst_sram_addr_ok, 0);
        tick();
        settle();
        chk("lock_c2_sram_addr", sram_addr, 32'h0000_2000);
        chk("lock_c2_sram_req", sram_req, 1);
        tick();
        sram_addr_ok = 1;
        settle();
        chk("lock_hs_data_addr_ok", data_sram_addr_ok, 1);
        chk("lock_hs_inst_addr_ok", inst_sram_addr_ok, 0);
        chk("lock_hs_sram_addr", sram_addr, 32'h0000_2000);
        tick();
        data_sram_req = 0;
        settle();
        chk("lock_after_sram_addr", sram_addr, 32'h1C00_0008);
        chk("lock_after_inst_addr_ok", inst_sram_addr_ok, 1);
        tick();

        // Two outstanding (data, inst): further requests blocked until a response pops
        inst_sram_addr = 32'h1C00_000C;
        settle();
        chk("full_sram_req", sram_req, 0);
        chk("full_inst_addr_ok", inst_sram_addr_ok, 0);
        tick();
        sram_data_ok = 1; sram_rdata = 32'h0000_0033;
        settle();
        chk("full_pop_sram_req", sram_req, 1);
        chk("full_pop_inst_addr_ok", inst_sram_addr_ok, 1);
        chk("full_pop_data_data_ok", data_sram_data_ok, 1);
        chk("full_pop_inst_data_ok", inst_sram_data_ok, 0);
        tick();
        sram_data_ok = 0;
        settle();
        chk("full_again_sram_req", sram_req, 0);
        inst_sram_req = 0; sram_addr_ok = 0;
        tick();
        sram_data_ok = 1;
        settle();
        chk("drain1_inst_data_ok", inst_sram_data_ok, 1);
        tick();
        settle();
        chk("drain2_inst_data_ok", inst_sram_data_ok, 1);
        tick();
        sram_data_ok = 0;
        settle();
        chk("drained_arb_err", arb_err, 0);

        // Continuous conflicting requests after reset
        do_reset();
        inst_sram_req = 1; inst_sram_addr = 32'h1C00_0100;
        data_sram_req = 1; data_sram_addr = 32'h0000_0100; sram_addr_ok = 1;
        settle();
        chk("cont1_sram_addr", sram_addr, 32'h0000_0100);
        tick();
        sram_data_ok = 1;
        settle();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        chk("cont2_sram_addr", sram_addr, 32'h1C00_0100);
`else
        chk("cont2_sram_addr", sram_addr, 32'h0000_0100);
`endif
        chk("cont2_data_data_ok", data_sram_data_ok, 1);
        tick();
        settle();
        chk("cont3_sram_addr", sram_addr, 32'h0000_0100);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        chk("cont3_inst_data_ok", inst_sram_data_ok, 1);
`else
        chk("cont3_data_data_ok", data_sram_data_ok, 1);
`endif
        tick();
        settle();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        chk("cont4_sram_addr", sram_addr, 32'h1C00_0100);
`else
        chk("cont4_sram_addr", sram_addr, 32'h0000_0100);
`endif
        chk("cont4_data_data_ok", data_sram_data_ok, 1);
        tick();
        inst_sram_req = 0; data_sram_req = 0; sram_addr_ok = 0; sram_data_ok = 0;

        // Stray response on an empty FIFO
        do_reset();
        sram_data_ok = 1;
        settle();
        chk("stray_inst_data_ok", inst_sram_data_ok, 0);
        chk("stray_data_data_ok", data_sram_data_ok, 0);
        chk("stray_err_before_edge", arb_err, 0);
        tick();
        sram_data_ok = 0;
        settle();
        chk("stray_err_set", arb_err, 1);
        tick();
        tick();
        chk("stray_err_sticky", arb_err, 1);

        // Reset while a request is outstanding drops its ownership
        do_reset();
        chk("rerst_arb_err", arb_err, 0);
        data_sram_req = 1; data_sram_addr = 32'h0000_3000; sram_addr_ok = 1;
        settle();
        chk("mid_data_addr_ok", data_sram_addr_ok, 1);
        tick();
        data_sram_req = 0; sram_addr_ok = 0;
        do_reset();
        sram_data_ok = 1;
        settle();
        chk("mid_data_data_ok", data_sram_data_ok, 0);
        tick();
        sram_data_ok = 0;
        settle();
        chk("mid_arb_err", arb_err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
